// File: rtl/serial_addsub_core_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor stage.
// The master side issues operands and a start request; the slave returns result and status.
interface serial_addsub_core_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] flippedB;
  logic             m;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, A, flippedB, m,
    input  S, cout, ovf, zero, busy, done
  );

  modport slave (
    input  start, A, flippedB, m,
    output S, cout, ovf, zero, busy, done
  );
endinterface

// File: rtl/serial_addsub_core.sv
// Bit-serial WIDTH-bit adder/subtractor: S = A + flippedB + m, one bit per clock, LSB first,
// through a single full adder, with registered status flags and a one-cycle done pulse.
module serial_addsub_core #(
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   serial_addsub_core_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, s_q;
   logic [CW-1:0]    bit_cnt;
   logic             carry;
   logic             cout_q, ovf_q, zero_q, busy_q, done_q;
   logic             sum_bit, carry_next, last_bit;
   logic [WIDTH-1:0] s_shifted;

   assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
   assign last_bit   = (bit_cnt == CW'(WIDTH - 1));
   assign s_shifted  = {sum_bit, s_q[WIDTH-1:1]};

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (last_bit)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         s_q     <= '0;
         bit_cnt <= '0;
         carry   <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // busy/done are registered copies of the state being entered.
         busy_q <= (state_next == RUN);
         done_q <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh    <= bus.A;
                  b_sh    <= bus.flippedB;
                  carry   <= bus.m;
                  bit_cnt <= '0;
                  s_q     <= '0;
                  cout_q  <= 1'b0;
                  ovf_q   <= 1'b0;
                  zero_q  <= 1'b0;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               carry   <= carry_next;
               s_q     <= s_shifted;
               bit_cnt <= bit_cnt + 1'b1;
               if (last_bit) begin
                  // carry still holds the carry into the MSB at this point.
                  cout_q <= carry_next;
                  ovf_q  <= carry ^ carry_next;
                  zero_q <= (s_shifted == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.S    = s_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule
